cp0_vec_irq: RTL and testbench

- Parametrised coprocessor-0 for the pipelined MIPS core.
- Supports NUM_IRQ edge-triggered external interrupt lines, a per-line mask, a global enable and fixed-priority selection.
- Provides a Cause register that records the taken line, an EPC/handler-base pair, and a COUNT/COMPARE timer interrupt.
- Reads are serviced in ID, writes/ERET in EXE, interrupt redirect is generated toward the PC mux.

---
 rtl/cp0_vec_irq.sv | 156 +++++++++++++++
 tb/tb_cp0_vec_irq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_vec_irq.sv
// Coprocessor-0 for the pipelined MIPS core: edge-triggered vectored interrupts,
// Status/Cause/EPC/EHBR registers and a COUNT/COMPARE timer interrupt.
module cp0_vec_irq #(
  parameter int unsigned NUM_IRQ  = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TIMER_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        oper,
  input  logic [4:0]        addr_r,
  output logic [DATA_W-1:0] data_r,
  input  logic [4:0]        addr_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic              ir_en,
  input  logic [NUM_IRQ-1:0] ir_in,
  input  logic [DATA_W-1:0] ret_addr,
  output logic              jump_en,
  output logic [DATA_W-1:0] jump_addr,
  output logic              in_handler,
  output logic              irq_pending
);

  localparam int unsigned CODE_W  = 5;
  localparam int unsigned IRQ_LSB = 8;
  localparam int unsigned TBIT    = IRQ_LSB + NUM_IRQ;
  localparam bit          TIMER_ON = (TIMER_EN != 0);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_EHBR    = 5'd15;

  localparam logic [1:0] OP_MTC0 = 2'b10;
  localparam logic [1:0] OP_ERET = 2'b11;

  logic [DATA_W-1:0]  count_q, compare_q, epc_q, ehbr_q;
  logic               ie_q, exl_q;
  logic [NUM_IRQ-1:0] mask_q, pend_q, ir_prev_q;
  logic               tmask_q, tpend_q;
  logic [CODE_W-1:0]  code_q;
  logic               jump_en_q;
  logic [DATA_W-1:0]  jump_addr_q;

  logic               is_eret, is_mtc0;
  logic               wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ehbr;
  logic [NUM_IRQ:0]   act;
  logic               take;
  logic               timer_hit;
  logic [NUM_IRQ-1:0] rise, w1c_irq;
  logic [CODE_W-1:0]  sel_idx;

  assign is_eret    = (oper == OP_ERET);
  assign is_mtc0    = (oper == OP_MTC0);
  assign wr_count   = is_mtc0 && (addr_w == A_COUNT);
  assign wr_compare = is_mtc0 && (addr_w == A_COMPARE);
  assign wr_status  = is_mtc0 && (addr_w == A_STATUS);
  assign wr_cause   = is_mtc0 && (addr_w == A_CAUSE);
  assign wr_epc     = is_mtc0 && (addr_w == A_EPC);
  assign wr_ehbr    = is_mtc0 && (addr_w == A_EHBR);

  // Timer sits just above the external lines, so it naturally gets lowest priority.
  assign act         = {tpend_q & tmask_q, pend_q & mask_q};
  assign irq_pending = |act;
  assign take        = ir_en && ie_q && !exl_q && (|act) && !is_eret && !is_mtc0;
  assign timer_hit   = TIMER_ON && (compare_q != '0) && (count_q == compare_q);
  assign rise        = ir_in & ~ir_prev_q;
  assign w1c_irq     = wr_cause ? data_w[IRQ_LSB +: NUM_IRQ] : '0;

  // Lowest set index wins.
  always_comb begin
    sel_idx = CODE_W'(NUM_IRQ);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (act[i]) sel_idx = CODE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      compare_q   <= '0;
      epc_q       <= '0;
      ehbr_q      <= '0;
      ie_q        <= 1'b0;
      exl_q       <= 1'b0;
      mask_q      <= '0;
      pend_q      <= '0;
      ir_prev_q   <= '0;
      tmask_q     <= 1'b0;
      tpend_q     <= 1'b0;
      code_q      <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      ir_prev_q   <= ir_in;
      jump_en_q   <= is_eret || take;
      jump_addr_q <= is_eret ? epc_q : (take ? ehbr_q : '0);

      count_q <= wr_count ? data_w : count_q + DATA_W'(1);
      if (wr_compare) compare_q <= data_w;
      if (wr_ehbr)    ehbr_q    <= data_w;

      if (wr_epc)    epc_q <= data_w;
      else if (take) epc_q <= ret_addr;

      if (wr_status) begin
        ie_q    <= data_w[0];
        mask_q  <= data_w[IRQ_LSB +: NUM_IRQ];
        tmask_q <= data_w[TBIT];
      end

      if (is_eret)        exl_q <= 1'b0;
      else if (wr_status) exl_q <= data_w[1];
      else if (take)      exl_q <= 1'b1;

      if (take) code_q <= sel_idx;

      // A new edge beats a same-cycle W1C of the same bit.
      pend_q <= (pend_q & ~w1c_irq) | rise;

      if (wr_compare)                   tpend_q <= 1'b0;
      else if (timer_hit)               tpend_q <= 1'b1;
      else if (wr_cause && data_w[TBIT]) tpend_q <= 1'b0;
    end
  end

  assign jump_en    = jump_en_q;
  assign jump_addr  = jump_addr_q;
  assign in_handler = exl_q;

  // Read port shows pre-edge state; no write bypass.
  always_comb begin
    data_r = '0;
    case (addr_r)
      A_COUNT:   data_r = count_q;
      A_COMPARE: data_r = compare_q;
      A_STATUS: begin
        data_r[0]                  = ie_q;
        data_r[1]                  = exl_q;
        data_r[IRQ_LSB +: NUM_IRQ] = mask_q;
        data_r[TBIT]               = tmask_q;
      end
      A_CAUSE: begin
        data_r[6:2]                = code_q;
        data_r[IRQ_LSB +: NUM_IRQ] = pend_q;
        data_r[TBIT]               = tpend_q;
      end
      A_EPC:     data_r = epc_q;
      A_EHBR:    data_r = ehbr_q;
      default:   data_r = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_vec_irq.sv
// Self-checking bench for cp0_vec_irq: directed scenarios plus randomized traffic
// compared against a register-word level reference model.
module tb_cp0_vec_irq;

  localparam logic [31:0] PMASK = 32'h0000_1F00;
  localparam logic [31:0] SMASK = 32'h0000_1F03;
  localparam logic [31:0] TBIT  = 32'h0000_1000;
  localparam logic [31:0] CODEF = 32'h0000_007C;

  logic        clk, rst;
  logic [1:0]  oper;
  logic [4:0]  addr_r, addr_w;
  logic [31:0] data_r, data_w, ret_addr, jump_addr;
  logic        ir_en, jump_en, in_handler, irq_pending;
  logic [3:0]  ir_in;

  int checks = 0;
  int errors = 0;

  // Reference model state: whole register words.
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_ehbr, m_jaddr;
  logic        m_jen;
  logic [3:0]  m_prev;

  cp0_vec_irq #(.NUM_IRQ(4), .DATA_W(32), .TIMER_EN(1)) dut (
    .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
    .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr),
    .in_handler(in_handler), .irq_pending(irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mread(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return m_ehbr;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] act, rise, n_count, n_compare, n_status, n_cause, n_epc, n_ehbr, n_jaddr;
    logic n_jen, take, cmp_wr, cnt_wr, found;
    int code;
    if (rst) begin
      m_count = 0; m_compare = 0; m_status = 0; m_cause = 0;
      m_epc = 0; m_ehbr = 0; m_jaddr = 0; m_jen = 0; m_prev = 0;
      return;
    end
    act  = m_cause & m_status & PMASK;
    take = ir_en && m_status[0] && !m_status[1] && (act != 0);
    rise = {28'h0, ir_in & ~m_prev} << 8;
    n_count = m_count; n_compare = m_compare; n_status = m_status; n_cause = m_cause;
    n_epc = m_epc; n_ehbr = m_ehbr; n_jen = 0; n_jaddr = 0; cmp_wr = 0; cnt_wr = 0;
    if (oper == 2'b11) begin
      n_jen = 1; n_jaddr = m_epc; n_status[1] = 1'b0;
    end else if (oper == 2'b10) begin
      case (addr_w)
        5'd9:  begin n_count = data_w; cnt_wr = 1; end
        5'd11: begin n_compare = data_w; cmp_wr = 1; n_cause = n_cause & ~TBIT; end
        5'd12: n_status = data_w & SMASK;
        5'd13: n_cause = n_cause & ~(data_w & PMASK);
        5'd14: n_epc = data_w;
        5'd15: n_ehbr = data_w;
        default: ;
      endcase
    end else if (take) begin
      n_jen = 1; n_jaddr = m_ehbr; n_epc = ret_addr; n_status[1] = 1'b1;
      found = 0; code = 0;
      for (int b = 0; b <= 4; b++) begin
        if (!found && act[8+b]) begin code = b; found = 1; end
      end
      n_cause = (n_cause & ~CODEF) | (32'(code) << 2);
    end
    n_cause = n_cause | rise;
    if (m_compare != 0 && m_count == m_compare && !cmp_wr) n_cause = n_cause | TBIT;
    if (!cnt_wr) n_count = m_count + 32'd1;
    m_count = n_count; m_compare = n_compare; m_status = n_status; m_cause = n_cause;
    m_epc = n_epc; m_ehbr = n_ehbr; m_jen = n_jen; m_jaddr = n_jaddr; m_prev = ir_in;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    oper = 2'b10; addr_w = a; data_w = d;
    cyc();
    oper = 2'b00;
  endtask

  task automatic eret();
    oper = 2'b11;
    cyc();
    oper = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1; oper = 0; ir_in = 0; ir_en = 0;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [4:0] regs [6];
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    rst = 1; oper = 0; ir_in = 0; ir_en = 0; addr_w = 0; data_w = 0; ret_addr = 0; addr_r = 0;
    cyc(); cyc();
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL reset_jump_en got %b exp 0", jump_en); end
    checks++; if (jump_addr !== 32'h0) begin errors++; $display("FAIL reset_jump_addr got %h exp 0", jump_addr); end
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL reset_in_handler got %b exp 0", in_handler); end
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL reset_irq_pending got %b exp 0", irq_pending); end
    foreach (regs[i]) begin
      addr_r = regs[i]; #1;
      checks++;
      if (data_r !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", regs[i], data_r); end
    end
    rst = 0;
  endtask

  task automatic test_irq_basic();
    do_reset();
    ir_en = 1; ret_addr = 32'h40;
    mtc0(5'd15, 32'h100);
    mtc0(5'd12, 32'h0000_0301);
    ir_in = 4'b0010;
    cyc();
    checks++; if (irq_pending !== 1'b1) begin errors++; $display("FAIL basic_pending got %b exp 1", irq_pending); end
    cyc();
    checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL basic_jump_en got %b exp 1", jump_en); end
    checks++; if (jump_addr !== 32'h100) begin errors++; $display("FAIL basic_jump_addr got %h exp 100", jump_addr); end
    checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL basic_in_handler got %b exp 1", in_handler); end
    addr_r = 5'd14; #1;
    checks++; if (data_r !== 32'h40) begin errors++; $display("FAIL basic_epc got %h exp 40", data_r); end
    addr_r = 5'd13; #1;
    checks++; if (data_r[6:2] !== 5'd1) begin errors++; $display("FAIL basic_code got %0d exp 1", data_r[6:2]); end
    cyc();
    checks++;
    if (jump_en !== 1'b0 || jump_addr !== 32'h0) begin
      errors++; $display("FAIL basic_pulse_end got en=%b addr=%h exp en=0 addr=0", jump_en, jump_addr);
    end
  endtask

  task automatic test_priority();
    do_reset();
    ir_en = 1; ret_addr = 32'h80;
    mtc0(5'd15, 32'h100);
    mtc0(5'd12, 32'h0000_0901);
    ir_in = 4'b1001;
    cyc(); cyc();
    checks++; if (jump_en !== 1'b1 || jump_addr !== 32'h100) begin
      errors++; $display("FAIL prio_first_take got en=%b addr=%h exp en=1 addr=100", jump_en, jump_addr); end
    addr_r = 5'd13; #1;
    checks++; if (data_r !== 32'h900) begin errors++; $display("FAIL prio_cause0 got %h exp 900", data_r); end
    mtc0(5'd13, 32'h100);
    checks++; if (data_r !== 32'h800) begin errors++; $display("FAIL prio_w1c got %h exp 800", data_r); end
    eret();
    checks++; if (jump_en !== 1'b1 || jump_addr !== 32'h80 || in_handler !== 1'b0) begin
      errors++; $display("FAIL prio_eret got en=%b addr=%h exl=%b exp en=1 addr=80 exl=0", jump_en, jump_addr, in_handler); end
    cyc();
    checks++; if (jump_en !== 1'b1 || jump_addr !== 32'h100 || in_handler !== 1'b1) begin
      errors++; $display("FAIL prio_reenter got en=%b addr=%h exl=%b exp en=1 addr=100 exl=1", jump_en, jump_addr, in_handler); end
    checks++; if (data_r !== 32'h80C) begin errors++; $display("FAIL prio_cause3 got %h exp 80c", data_r); end
  endtask

  task automatic test_eret();
    do_reset();
    ir_en = 1; ret_addr = 32'h40;
    mtc0(5'd15, 32'h100);
    mtc0(5'd12, 32'h0000_0201);
    ir_in = 4'b0010;
    cyc(); cyc();
    ret_addr = 32'h999;
    mtc0(5'd13, 32'h200);
    checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL eret_cleared got %b exp 0", irq_pending); end
    eret();
    checks++; if (jump_en !== 1'b1 || jump_addr !== 32'h40 || in_handler !== 1'b0) begin
      errors++; $display("FAIL eret_redirect got en=%b addr=%h exl=%b exp en=1 addr=40 exl=0", jump_en, jump_addr, in_handler); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (jump_en !== 1'b0) begin errors++; $display("FAIL eret_no_retrigger%0d got %b exp 0", k, jump_en); end
    end
  endtask

  task automatic test_mtc0_collision();
    do_reset();
    ir_en = 1; ret_addr = 32'h44;
    mtc0(5'd15, 32'h100);
    mtc0(5'd12, 32'h0000_0201);
    ir_in = 4'b0010;
    cyc();
    mtc0(5'd14, 32'h1234);
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL coll_no_redirect got %b exp 0", jump_en); end
    addr_r = 5'd14; #1;
    checks++; if (data_r !== 32'h1234) begin errors++; $display("FAIL coll_write_visible got %h exp 1234", data_r); end
    cyc();
    checks++; if (jump_en !== 1'b1 || jump_addr !== 32'h100) begin
      errors++; $display("FAIL coll_late_take got en=%b addr=%h exp en=1 addr=100", jump_en, jump_addr); end
    checks++; if (data_r !== 32'h44) begin errors++; $display("FAIL coll_epc got %h exp 44", data_r); end
  endtask

  task automatic test_timer();
    bit got;
    do_reset();
    ir_en = 1;
    mtc0(5'd15, 32'h200);
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h0000_1001);
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      cyc();
      if (jump_en === 1'b1) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL timer_timeout got no redirect exp redirect"); end
    checks++; if (jump_addr !== 32'h200) begin errors++; $display("FAIL timer_jump_addr got %h exp 200", jump_addr); end
    addr_r = 5'd9; #1;
    checks++; if (data_r !== 32'd22) begin errors++; $display("FAIL timer_count_at_take got %0d exp 22", data_r); end
    addr_r = 5'd13; #1;
    checks++; if (data_r !== 32'h1010) begin errors++; $display("FAIL timer_cause got %h exp 1010", data_r); end
    mtc0(5'd11, 32'd1000);
    checks++; if (data_r !== 32'h10) begin errors++; $display("FAIL timer_compare_clear got %h exp 10", data_r); end
    mtc0(5'd9, 32'hFFFF_FFFF);
    addr_r = 5'd9; #1;
    checks++; if (data_r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_count_load got %h exp ffffffff", data_r); end
    cyc();
    checks++; if (data_r !== 32'h0) begin errors++; $display("FAIL timer_wrap got %h exp 0", data_r); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] regs [6];
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    do_reset();
    ir_en = 1; ret_addr = 32'h60;
    mtc0(5'd15, 32'h100);
    mtc0(5'd12, 32'h0000_0301);
    ir_in = 4'b0011;
    cyc(); cyc();
    checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL rmid_entered got %b exp 1", in_handler); end
    rst = 1; ir_in = 4'b0000;
    cyc();
    checks++; if (jump_en !== 1'b0 || jump_addr !== 32'h0) begin
      errors++; $display("FAIL rmid_pulse_drop got en=%b addr=%h exp en=0 addr=0", jump_en, jump_addr); end
    checks++; if (in_handler !== 1'b0 || irq_pending !== 1'b0) begin
      errors++; $display("FAIL rmid_state got exl=%b pend=%b exp 0 0", in_handler, irq_pending); end
    foreach (regs[i]) begin
      addr_r = regs[i]; #1;
      checks++;
      if (data_r !== 32'h0) begin errors++; $display("FAIL rmid_reg%0d got %h exp 0", regs[i], data_r); end
    end
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (jump_en !== 1'b0) begin errors++; $display("FAIL rmid_quiet%0d got %b exp 0", k, jump_en); end
    end
    mtc0(5'd15, 32'h100);
    mtc0(5'd12, 32'h0000_0201);
    ir_in = 4'b0010;
    cyc(); cyc();
    checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL rmid_new_edge got %b exp 1", jump_en); end
  endtask

  task automatic test_random();
    logic [4:0] waddrs [10];
    int r;
    waddrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd12, 5'd13, 5'd12};
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      r = int'($urandom_range(0, 9));
      oper = (r < 5) ? 2'b00 : (r == 5) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
      addr_w = waddrs[$urandom_range(0, 9)];
      data_w = $urandom;
      if (addr_w == 5'd12) begin
        data_w[0] = ($urandom_range(0, 4) != 0);
        data_w[1] = ($urandom_range(0, 4) == 0);
      end else if (addr_w == 5'd11) begin
        data_w = m_count + 32'($urandom_range(2, 40));
      end
      ir_in = ir_in ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      ir_en = ($urandom_range(0, 3) != 0);
      ret_addr = $urandom;
      addr_r = 5'($urandom_range(8, 16));
      cyc();
      checks++; if (jump_en !== m_jen) begin errors++; $display("FAIL rnd_jump_en cyc%0d got %b exp %b", n, jump_en, m_jen); end
      checks++; if (jump_addr !== m_jaddr) begin errors++; $display("FAIL rnd_jump_addr cyc%0d got %h exp %h", n, jump_addr, m_jaddr); end
      checks++; if (in_handler !== m_status[1]) begin errors++; $display("FAIL rnd_in_handler cyc%0d got %b exp %b", n, in_handler, m_status[1]); end
      checks++; if (irq_pending !== ((m_cause & m_status & PMASK) != 0)) begin
        errors++; $display("FAIL rnd_irq_pending cyc%0d got %b exp %b", n, irq_pending, (m_cause & m_status & PMASK) != 0); end
      checks++; if (data_r !== mread(addr_r)) begin
        errors++; $display("FAIL rnd_data_r cyc%0d addr %0d got %h exp %h", n, addr_r, data_r, mread(addr_r)); end
    end
    rst = 0; oper = 0;
  endtask

  initial begin
    test_reset();
    test_irq_basic();
    test_priority();
    test_eret();
    test_mtc0_collision();
    test_timer();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
